// File: rtl/stonyman_readout.sv
// Stonyman image sensor frame sequencer with SPI ADC capture.
// Walks rows/columns, converts each pixel and hands it out over ready/valid.
module stonyman_readout #(
  parameter int ROWS       = 112,
  parameter int COLS       = 112,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 8,
  parameter int SCLK_DIV   = 2,
  parameter int ADC_BITS   = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                resv,
  output logic                resp,
  output logic                incv,
  output logic                incp,
  output logic                inphi,
  output logic                cs_n,
  output logic                sclk,
  input  logic                miso,
  output logic [ADC_BITS-1:0] pix_data,
  output logic [7:0]          pix_row,
  output logic [7:0]          pix_col,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                frame_done
);

  typedef enum logic [3:0] {
    IDLE, RESV, RESP, SETTLE, CONV,
    OUT, INCP, INCV, DONE
  } state_e;

  localparam logic [15:0] P1   = 16'(PULSE_CYC - 1);
  localparam logic [15:0] PC   = 16'(PULSE_CYC);
  localparam logic [15:0] S1   = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] HD   = 16'(SCLK_DIV);
  localparam logic [15:0] PER1 = 16'(2 * SCLK_DIV - 1);
  localparam logic [7:0]  LR   = 8'(ROWS - 1);
  localparam logic [7:0]  LC   = 8'(COLS - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [7:0]          row_q, row_d;
  logic [7:0]          col_q, col_d;
  logic [15:0]         sh_q, sh_d;
  logic [ADC_BITS-1:0] pd_q, pd_d;

  logic busy_q, busy_d;
  logic resv_q, resv_d;
  logic resp_q, resp_d;
  logic incv_q, incv_d;
  logic incp_q, incp_d;
  logic inphi_q, inphi_d;
  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic vld_q, vld_d;
  logic fd_q, fd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    row_d   = row_q;
    col_d   = col_q;
    sh_d    = sh_q;
    pd_d    = pd_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = RESV;
      end
      RESV: begin
        row_d = '0;
        if (cnt_q == P1) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        col_d = '0;
        if (cnt_q == P1) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == S1) begin
          state_d = CONV;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      CONV: begin
        // first clk cycle of the sclk high phase
        if (cnt_q == HD) sh_d = {sh_q[14:0], miso};
        if (cnt_q == PER1) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_d = OUT;
            pd_d    = sh_d[ADC_BITS-1:0];
          end
        end
      end
      OUT: begin
        cnt_d = '0;
        if (pix_ready) state_d = INCP;
      end
      INCP: begin
        if (cnt_q == P1) begin
          cnt_d = '0;
          if (col_q < LC) begin
            col_d   = col_q + 8'd1;
            state_d = SETTLE;
          end else if (row_q < LR) begin
            state_d = INCV;
          end else begin
            state_d = DONE;
          end
        end
      end
      INCV: begin
        if (cnt_q == P1) begin
          cnt_d   = '0;
          row_d   = row_q + 8'd1;
          state_d = RESP;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d  = state_d != IDLE;
    resv_d  = state_d == RESV;
    resp_d  = state_d == RESP;
    incv_d  = state_d == INCV;
    incp_d  = state_d == INCP;
    inphi_d = (state_d == SETTLE) && (cnt_d < PC);
    cs_n_d  = state_d != CONV;
    sclk_d  = (state_d == CONV) && (cnt_d >= HD);
    vld_d   = state_d == OUT;
    fd_d    = state_d == DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sh_q    <= '0;
      pd_q    <= '0;
      busy_q  <= 1'b0;
      resv_q  <= 1'b0;
      resp_q  <= 1'b0;
      incv_q  <= 1'b0;
      incp_q  <= 1'b0;
      inphi_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      vld_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sh_q    <= sh_d;
      pd_q    <= pd_d;
      busy_q  <= busy_d;
      resv_q  <= resv_d;
      resp_q  <= resp_d;
      incv_q  <= incv_d;
      incp_q  <= incp_d;
      inphi_q <= inphi_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      vld_q   <= vld_d;
      fd_q    <= fd_d;
    end
  end

  assign busy       = busy_q;
  assign resv       = resv_q;
  assign resp       = resp_q;
  assign incv       = incv_q;
  assign incp       = incp_q;
  assign inphi      = inphi_q;
  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign pix_data   = pd_q;
  assign pix_row    = row_q;
  assign pix_col    = col_q;
  assign pix_valid  = vld_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_stonyman_readout.sv
// Bench for stonyman_readout: ADC model, pixel scoreboard and pulse monitors
// on a 2x3 sensor instance and a 1x1 sensor instance.
module tb_stonyman_readout;

  localparam logic [15:0] FIXED = 16'h0ABC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [2];
  logic busy [2];
  logic resv [2];
  logic resp [2];
  logic incv [2];
  logic incp [2];
  logic inphi [2];
  logic cs_n [2];
  logic sclk [2];
  logic pval [2];
  logic fdone [2];
  logic [11:0] pdata [2];
  logic [7:0] prow [2];
  logic [7:0] pcol [2];

  bit fixed_en [2];
  bit stall_arm [2];
  bit rand_rdy [2];
  int frames_a [2];
  int rises_a [2];
  int stc_a [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_d
    localparam int R = (g == 0) ? 2 : 1;
    localparam int C = (g == 0) ? 3 : 1;
    logic miso_l = 1'b0;
    logic rdy_l = 1'b0;
    logic [15:0] word = '0;
    logic [11:0] dq [$];
    logic [4:0] pp = '0;
    logic [27:0] pview = '0;
    logic pcs = 1'b1;
    logic psclk = 1'b0;
    logic phold = 1'b0;
    bit sdone = 1'b0;
    int idx = 0, span = 0, rises = 0;
    int viol = 0, npix = 0, stall = 0;
    int st_cyc = 0, frames = 0;
    int cnt [5];
    int wid [5];

    assign frames_a[g] = frames;
    assign rises_a[g]  = rises;
    assign stc_a[g]    = st_cyc;

    stonyman_readout #(
      .ROWS(R), .COLS(C), .PULSE_CYC(2),
      .SETTLE_CYC(4), .SCLK_DIV(2), .ADC_BITS(12)
    ) u_dut (
      .clk(clk), .reset(rst), .start(start[g]),
      .busy(busy[g]), .resv(resv[g]), .resp(resp[g]),
      .incv(incv[g]), .incp(incp[g]), .inphi(inphi[g]),
      .cs_n(cs_n[g]), .sclk(sclk[g]), .miso(miso_l),
      .pix_data(pdata[g]), .pix_row(prow[g]),
      .pix_col(pcol[g]), .pix_valid(pval[g]),
      .pix_ready(rdy_l), .frame_done(fdone[g])
    );

    always @(negedge clk) begin
      logic [4:0] p;
      logic [11:0] d;
      logic [27:0] view;
      p = {resv[g], resp[g], incv[g], incp[g], inphi[g]};
      view = {pdata[g], prow[g], pcol[g]};
      if (rst) begin
        dq.delete();
        pp = '0; pcs = 1'b1; psclk = 1'b0; phold = 1'b0;
        idx = 0; span = 0; rises = 0; viol = 0;
        npix = 0; stall = 0; rdy_l = 1'b0; miso_l = 1'b0;
        for (int k = 0; k < 5; k++) begin
          cnt[k] = 0; wid[k] = 0;
        end
      end else begin
        // ADC side: new word per conversion, shifts on sclk fall
        if (pcs && !cs_n[g]) begin
          word = fixed_en[g] ? FIXED : 16'($urandom);
          dq.push_back(word[11:0]);
          idx = 0; span = 0; rises = 0;
        end
        if (!cs_n[g]) begin
          span++;
          if (sclk[g] && !psclk) rises++;
          if (!sclk[g] && psclk) idx++;
        end
        if (!pcs && cs_n[g]) begin
          chk("cs_low_len", span, 64);
          chk("sclk_rises", rises, 16);
        end
        if (cs_n[g] && sclk[g]) viol++;
        miso_l = (!cs_n[g] && idx < 16) ? word[15 - idx] : 1'b0;

        if ($countones(p) > 1) viol++;
        for (int k = 0; k < 5; k++) begin
          if (p[k] && !pp[k]) begin
            cnt[k]++; wid[k] = 0;
          end
          if (p[k]) wid[k]++;
          if (!p[k] && pp[k] && wid[k] != 2) viol++;
        end

        if (phold && (!pval[g] || view != pview)) viol++;
        if (pval[g]) begin
          if ((|p) || sclk[g] || !cs_n[g]) viol++;
          if (stall_arm[g] && npix == 1 && !sdone) begin
            stall = 50; sdone = 1'b1;
          end
          if (stall > 0) begin
            rdy_l = 1'b0; stall--; st_cyc++;
          end else begin
            rdy_l = !rand_rdy[g] || ($urandom_range(0, 3) != 0);
          end
          if (rdy_l) begin
            if (dq.size() == 0) viol++;
            else begin
              d = dq.pop_front();
              chk("pix_data", pdata[g], d);
            end
            chk("pix_row", prow[g], npix / C);
            chk("pix_col", pcol[g], npix % C);
            npix++;
          end
          pview = view;
          phold = !rdy_l;
        end else begin
          rdy_l = 1'b0;
          phold = 1'b0;
        end

        if (fdone[g]) begin
          chk("n_pix", npix, R * C);
          chk("n_resv", cnt[4], 1);
          chk("n_resp", cnt[3], R);
          chk("n_incv", cnt[2], R - 1);
          chk("n_incp", cnt[1], R * C);
          chk("n_inphi", cnt[0], R * C);
          chk("violations", viol, 0);
          chk("adc_left", dq.size(), 0);
          npix = 0; viol = 0;
          for (int k = 0; k < 5; k++) cnt[k] = 0;
          frames++;
        end
        pp = p; pcs = cs_n[g]; psclk = sclk[g];
      end
    end
  end

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
  endtask

  task automatic wait_frame(input int g, input int n);
    int t;
    t = 0;
    while (frames_a[g] < n && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("frame_wait", 32'(frames_a[g] >= n), 1);
    chk("busy_off", busy[g], 0);
  endtask

  initial begin
    bit hit;
    start[0] = 1'b0; start[1] = 1'b0;
    fixed_en[0] = 1'b1; fixed_en[1] = 1'b0;
    stall_arm[0] = 1'b1; stall_arm[1] = 1'b0;
    rand_rdy[0] = 1'b0; rand_rdy[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_csn", cs_n[0], 1);
    chk("rst_valid", pval[0], 0);
    chk("rst_pulses", {resv[0], resp[0], incv[0], incp[0], inphi[0]}, 0);
    rst = 1'b0;

    pulse_start(0);
    chk("busy_on", busy[0], 1);
    repeat (100) @(posedge clk);
    pulse_start(0);
    wait_frame(0, 1);
    repeat (200) @(posedge clk);
    #1;
    chk("one_frame", frames_a[0], 1);
    chk("stall_cycles", stc_a[0], 50);

    fixed_en[0] = 1'b0; stall_arm[0] = 1'b0; rand_rdy[0] = 1'b1;
    pulse_start(0);
    wait_frame(0, 2);

    pulse_start(0);
    hit = 1'b0;
    for (int t = 0; t < 20000 && !hit; t++) begin
      @(posedge clk); #1;
      hit = prow[0] == 8'd1 && pcol[0] == 8'd0 && !cs_n[0]
            && sclk[0] && rises_a[0] == 7;
    end
    chk("reset_point", hit, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_csn", cs_n[0], 1);
    chk("mid_rst_outs",
        {busy[0], resv[0], resp[0], incv[0], incp[0], inphi[0],
         sclk[0], pval[0], fdone[0]}, 0);
    chk("mid_rst_pix", {pdata[0], prow[0], pcol[0]}, 0);
    pulse_start(0);
    wait_frame(0, 3);
    chk("frames_after_rst", frames_a[0], 3);

    pulse_start(1);
    wait_frame(1, 1);
    pulse_start(1);
    wait_frame(1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
